// File: rtl/arb_pkg.sv
// Shared types for the sram bus arbiter: bus ownership states, grant
// selector and the fixed fetch access size.
package arb_pkg;

  // Bus ownership: IDLE accepts a new address phase, WAIT_x waits for data.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  // Which requester owns (or is being offered) the master port.
  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  // Fetches are always full 4-byte words.
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selector: fixed data priority or round-robin on the
// last accepted grant. Only meaningful while at least one port requests.
module arb_grant
  import arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic   inst_req,
  input  logic   data_req,
  input  grant_t last_grant,
  output grant_t grant
);

  // Single requester wins outright; contention resolved by policy.
  always_comb begin
    grant = GRANT_INST;
    if (data_req && !inst_req) begin
      grant = GRANT_DATA;
    end else if (data_req && inst_req) begin
      if (DATA_PRIORITY != 0) begin
        grant = GRANT_DATA;
      end else begin
        grant = (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
      end
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Serializes the fetch port and the load/store port onto one sram-like
// master port. One transaction in flight: address phase, then data phase.
// Address accept and data return are routed back to the owning port
// combinationally; a new grant is possible the cycle after data_ok.
module sram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_uncached,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_uncached,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // master port
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_uncached,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  state_t state;
  state_t state_nxt;
  grant_t last_grant;
  grant_t grant;
  logic   any_req;
  logic   in_idle;
  logic   accept;

  assign any_req = inst_req | data_req;
  assign in_idle = (state == IDLE);
  // Address phase completes only while idle; WAIT_x never raises m_req.
  assign accept  = in_idle & any_req & m_addr_ok;

  // Grant is recomputed every idle cycle so a withdrawn request can be
  // replaced before the master accepts.
  arb_grant #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_grant (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .last_grant(last_grant),
    .grant     (grant)
  );

  // Next-state: accept moves to the owner's wait state, data_ok releases.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (grant == GRANT_DATA) ? WAIT_D : WAIT_I;
      end
      WAIT_I, WAIT_D: begin
        if (m_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and round-robin history; last_grant only moves on an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_INST;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= grant;
    end
  end

  // Master drive: only in IDLE with a pending request, from the granted port.
  always_comb begin
    m_req      = 1'b0;
    m_wr       = 1'b0;
    m_size     = 2'b00;
    m_addr     = 32'h0;
    m_wdata    = 32'h0;
    m_uncached = 1'b0;
    if (in_idle && any_req) begin
      m_req = 1'b1;
      if (grant == GRANT_DATA) begin
        m_wr       = data_wr;
        m_size     = data_size;
        m_addr     = data_addr;
        m_wdata    = data_wdata;
        m_uncached = data_uncached;
      end else begin
        m_wr       = 1'b0;
        m_size     = SIZE_WORD;
        m_addr     = inst_addr;
        m_wdata    = 32'h0;
        m_uncached = inst_uncached;
      end
    end
  end

  // Response routing: addr_ok to the granted port, data_ok/rdata to the
  // owner; rdata is zeroed outside the owner's data_ok cycle.
  always_comb begin
    inst_addr_ok = accept & (grant == GRANT_INST);
    data_addr_ok = accept & (grant == GRANT_DATA);
    inst_data_ok = (state == WAIT_I) & m_data_ok;
    data_data_ok = (state == WAIT_D) & m_data_ok;
    inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
    data_rdata   = data_data_ok ? m_rdata : 32'h0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: two instances (round-robin and data-priority)
// share all inputs; a transaction-level owner model predicts every output
// each cycle. Directed scenarios first, then random traffic.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_uncached;
  logic [31:0] inst_addr;
  logic        data_req, data_wr, data_uncached;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  // index 0: DATA_PRIORITY=0, index 1: DATA_PRIORITY=1
  logic        i_aok [2];
  logic        i_dok [2];
  logic [31:0] i_rd  [2];
  logic        d_aok [2];
  logic        d_dok [2];
  logic [31:0] d_rd  [2];
  logic        mreq  [2];
  logic        mwr   [2];
  logic [1:0]  msize [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdat [2];
  logic        munc  [2];

  // model: owner 0=none 1=fetch 2=data; last 1=fetch 2=data
  int owner [2];
  int last  [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.DATA_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_uncached(inst_uncached),
    .inst_addr_ok(i_aok[0]), .inst_data_ok(i_dok[0]), .inst_rdata(i_rd[0]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_uncached(data_uncached),
    .data_addr_ok(d_aok[0]), .data_data_ok(d_dok[0]), .data_rdata(d_rd[0]),
    .m_req(mreq[0]), .m_wr(mwr[0]), .m_size(msize[0]), .m_addr(maddr[0]),
    .m_wdata(mwdat[0]), .m_uncached(munc[0]),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  sram_bus_arbiter #(.DATA_PRIORITY(1)) u_dp (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_uncached(inst_uncached),
    .inst_addr_ok(i_aok[1]), .inst_data_ok(i_dok[1]), .inst_rdata(i_rd[1]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_uncached(data_uncached),
    .data_addr_ok(d_aok[1]), .data_data_ok(d_dok[1]), .data_rdata(d_rd[1]),
    .m_req(mreq[1]), .m_wr(mwr[1]), .m_size(msize[1]), .m_addr(maddr[1]),
    .m_wdata(mwdat[1]), .m_uncached(munc[1]),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Who the spec says gets the bus this cycle if idle (0 = nobody).
  function automatic int pick(input int k);
    if (inst_req && !data_req) return 1;
    if (data_req && !inst_req) return 2;
    if (inst_req && data_req) begin
      if (k == 1) return 2;
      return (last[k] == 2) ? 1 : 2;
    end
    return 0;
  endfunction

  // Sample at the falling edge and compare all outputs of both instances.
  task automatic check();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int g;
      logic        e_req, e_wr, e_unc;
      logic [1:0]  e_size;
      logic [31:0] e_addr, e_wdat;
      string p;
      p = (k == 0) ? "rr" : "dp";
      g = (owner[k] == 0) ? pick(k) : 0;
      e_req = (g != 0);
      e_wr = 0; e_size = 0; e_addr = 0; e_wdat = 0; e_unc = 0;
      if (g == 1) begin
        e_size = 2'd2; e_addr = inst_addr; e_unc = inst_uncached;
      end else if (g == 2) begin
        e_wr = data_wr; e_size = data_size; e_addr = data_addr;
        e_wdat = data_wdata; e_unc = data_uncached;
      end
      chk({p, "_m_req"},   32'(mreq[k]),  32'(e_req));
      chk({p, "_m_wr"},    32'(mwr[k]),   32'(e_wr));
      chk({p, "_m_size"},  32'(msize[k]), 32'(e_size));
      chk({p, "_m_addr"},  maddr[k],      e_addr);
      chk({p, "_m_wdata"}, mwdat[k],      e_wdat);
      chk({p, "_m_unc"},   32'(munc[k]),  32'(e_unc));
      chk({p, "_i_aok"},   32'(i_aok[k]), 32'(g == 1 && m_addr_ok));
      chk({p, "_d_aok"},   32'(d_aok[k]), 32'(g == 2 && m_addr_ok));
      chk({p, "_i_dok"},   32'(i_dok[k]), 32'(owner[k] == 1 && m_data_ok));
      chk({p, "_d_dok"},   32'(d_dok[k]), 32'(owner[k] == 2 && m_data_ok));
      chk({p, "_i_rd"},    i_rd[k], (owner[k] == 1 && m_data_ok) ? m_rdata : 32'h0);
      chk({p, "_d_rd"},    d_rd[k], (owner[k] == 2 && m_data_ok) ? m_rdata : 32'h0);
    end
  endtask

  // Apply the clock edge to the model, then move past the edge.
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      int g;
      g = pick(k);
      if (rst) begin
        owner[k] = 0; last[k] = 1;
      end else if (owner[k] == 0) begin
        if (g != 0 && m_addr_ok) begin owner[k] = g; last[k] = g; end
      end else if (m_data_ok) begin
        owner[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check();
    advance();
  endtask

  task automatic quiet();
    inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  initial begin
    rst = 1; quiet();
    inst_addr = 0; inst_uncached = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; data_uncached = 0; m_rdata = 0;
    owner[0] = 0; owner[1] = 0; last[0] = 1; last[1] = 1;
    @(posedge clk); #1;
    step();                      // reset state: all outputs zero
    rst = 0;
    step();

    // 1: fetch only
    inst_req = 1; inst_addr = 32'h1FC00000; m_addr_ok = 1;
    check();
    chk("t1_m_addr", maddr[1], 32'h1FC00000);
    chk("t1_m_size", 32'(msize[1]), 32'd2);
    chk("t1_i_aok",  32'(i_aok[1]), 32'd1);
    advance();
    quiet(); step();
    m_data_ok = 1; m_rdata = 32'h3C08BFC0;
    check();
    chk("t1_i_dok", 32'(i_dok[1]), 32'd1);
    chk("t1_i_rd",  i_rd[1], 32'h3C08BFC0);
    chk("t1_d_dok", 32'(d_dok[1]), 32'd0);
    advance();
    quiet(); step();

    // 2: contention, data priority
    inst_req = 1; data_req = 1; data_addr = 32'h1000; data_wr = 1;
    data_wdata = 32'hDEADBEEF; data_size = 2; m_addr_ok = 1;
    check();
    chk("t2_d_aok",  32'(d_aok[1]), 32'd1);
    chk("t2_i_aok",  32'(i_aok[1]), 32'd0);
    chk("t2_m_wdat", mwdat[1], 32'hDEADBEEF);
    advance();
    data_req = 0; m_addr_ok = 0; step();
    m_data_ok = 1; m_rdata = 32'h0; step();
    m_data_ok = 0; m_addr_ok = 1;
    check();
    chk("t2_i_next", 32'(i_aok[1]), 32'd1);
    advance();
    quiet(); m_data_ok = 1; m_rdata = 32'h12345678; step();
    quiet(); step();

    // 3: round-robin alternation from reset: D I D I
    rst = 1; step(); rst = 0;
    inst_req = 1; data_req = 1; data_wr = 0;
    for (int n = 0; n < 4; n++) begin
      m_addr_ok = 1; m_data_ok = 0;
      check();
      chk("t3_rr_d_aok", 32'(d_aok[0]), 32'((n % 2) == 0));
      chk("t3_rr_i_aok", 32'(i_aok[0]), 32'((n % 2) == 1));
      advance();
      m_addr_ok = 0; m_data_ok = 1; m_rdata = $urandom; step();
    end
    quiet(); step();

    // 4: back-pressure for 3 cycles, then accept
    inst_req = 1; data_req = 1;
    for (int n = 0; n < 3; n++) step();
    m_addr_ok = 1; step();
    quiet(); m_data_ok = 1; step();
    quiet(); step();

    // 5: data blocked behind a slow fetch
    inst_req = 1; m_addr_ok = 1; step();
    quiet(); data_req = 1;
    for (int n = 0; n < 5; n++) begin
      check();
      chk("t5_d_aok_stall", 32'(d_aok[1]), 32'd0);
      chk("t5_m_req_stall", 32'(mreq[1]), 32'd0);
      advance();
    end
    m_data_ok = 1; m_rdata = 32'hCAFEF00D; step();
    m_data_ok = 0; m_addr_ok = 1;
    check();
    chk("t5_d_aok", 32'(d_aok[1]), 32'd1);
    advance();
    quiet(); step();

    // 6: reset while data owns the bus (master reset alongside)
    rst = 1; step(); rst = 0;
    check();
    chk("t6_m_req", 32'(mreq[0]), 32'd0);
    advance();
    inst_req = 1; inst_addr = 32'h1FC00010; m_addr_ok = 1; step();
    quiet(); m_data_ok = 1; m_rdata = 32'h0BADCAFE; step();
    quiet(); step();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      inst_req      = ($urandom_range(0, 99) < 60);
      data_req      = ($urandom_range(0, 99) < 60);
      inst_addr     = $urandom;
      inst_uncached = 1'($urandom);
      data_wr       = 1'($urandom);
      data_size     = 2'($urandom_range(0, 2));
      data_addr     = $urandom;
      data_wdata    = $urandom;
      data_uncached = 1'($urandom);
      m_addr_ok     = 1'($urandom);
      m_data_ok     = m_addr_ok ? 1'b0 : 1'($urandom);
      if (rst) m_data_ok = 0;
      m_rdata       = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
